// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter and the cache controller.
package tinyv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  localparam logic [3:0] BE_FULL = 4'hF;

  // Requester identities, also used for the round-robin last-grant record.
  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, load/store and memory-port signals around the arbiter.
// master: the arbiter's view; slave: the core and memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_data_valid;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [3:0]        d_be;
  logic              d_data_valid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_err;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ack, mem_rdata,
    output i_data_valid, i_rdata, d_data_valid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be, mem_err
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ack, mem_rdata,
    input  i_data_valid, i_rdata, d_data_valid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be, mem_err
  );

endinterface

// File: rtl/mem_port_arbiter_timeout_ctr.sv
// Saturating busy-cycle counter. o_tc flags the increment that reaches LIMIT.
module arb_timeout_ctr #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_tc
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] r_cnt;

  // Clear has priority; increment stops at LIMIT instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != W'(LIMIT))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = i_inc && (r_cnt >= W'(LIMIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and
// load/store. One transaction outstanding; memory port driven from registers.
// Optional macro MEM_PORT_ARBITER_RR_EN selects round-robin priority instead of
// fixed data-over-instruction priority.
module mem_port_arbiter
  import tinyv_mem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.master  bus
);

  arb_state_t        r_state;
  arb_state_t        w_next;

  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [3:0]        r_mem_be;
  logic              r_mem_err;
  logic              r_i_dv;
  logic              r_d_dv;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic w_i_elig;
  logic w_d_elig;
  logic w_pick_d;
  logic w_grant_i;
  logic w_grant_d;
  logic w_done;
  logic w_abort;
  logic w_busy;
  logic w_inc;
  logic w_clr;
  logic w_tc;

  // A requester in its completion cycle is masked so it can drop req cleanly.
  assign w_i_elig = bus.i_req && !r_i_dv;
  assign w_d_elig = bus.d_req && !r_d_dv;

`ifdef MEM_PORT_ARBITER_RR_EN
  logic r_last_grant;

  // On a tie, the requester not granted last wins.
  assign w_pick_d = w_d_elig && (!w_i_elig || (r_last_grant == OWNER_I));

  // Record the owner of every grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= OWNER_I;
    end else if (w_grant_d) begin
      r_last_grant <= OWNER_D;
    end else if (w_grant_i) begin
      r_last_grant <= OWNER_I;
    end
  end
`else
  assign w_pick_d = w_d_elig;
`endif

  assign w_busy = (r_state != IDLE);
  assign w_inc  = w_busy && !bus.mem_ack;
  assign w_clr  = (w_next == IDLE);

  arb_timeout_ctr #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk  (clk),
    .rst  (reset),
    .i_clr(w_clr),
    .i_inc(w_inc),
    .o_tc (w_tc)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and transaction control decode.
  always_comb begin
    w_next    = r_state;
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    w_done    = 1'b0;
    w_abort   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_d) begin
          w_grant_d = 1'b1;
          w_next    = BUSY_D;
        end else if (w_i_elig) begin
          w_grant_i = 1'b1;
          w_next    = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.mem_ack) begin
          w_done = 1'b1;
          w_next = IDLE;
        end else if (w_tc) begin
          w_abort = 1'b1;
          w_next  = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Memory-port registers, completion pulses and returned data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_mem_err   <= 1'b0;
      r_i_dv      <= 1'b0;
      r_d_dv      <= 1'b0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_i_dv <= 1'b0;
      r_d_dv <= 1'b0;
      if (w_grant_d) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= bus.d_we;
        r_mem_addr  <= bus.d_addr;
        r_mem_wdata <= bus.d_wdata;
        r_mem_be    <= bus.d_be;
      end else if (w_grant_i) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= 1'b0;
        r_mem_addr  <= bus.i_addr;
        r_mem_wdata <= '0;
        r_mem_be    <= BE_FULL;
      end
      if (w_done) begin
        r_mem_req <= 1'b0;
        if (r_state == BUSY_I) begin
          r_i_dv    <= 1'b1;
          r_i_rdata <= bus.mem_rdata;
        end else begin
          r_d_dv    <= 1'b1;
          r_d_rdata <= r_mem_we ? '0 : bus.mem_rdata;
        end
      end
      if (w_abort) begin
        r_mem_req <= 1'b0;
        r_mem_err <= 1'b1;
      end
    end
  end

  assign bus.mem_req      = r_mem_req;
  assign bus.mem_we       = r_mem_we;
  assign bus.mem_addr     = r_mem_addr;
  assign bus.mem_wdata    = r_mem_wdata;
  assign bus.mem_be       = r_mem_be;
  assign bus.mem_err      = r_mem_err;
  assign bus.i_data_valid = r_i_dv;
  assign bus.i_rdata      = r_i_rdata;
  assign bus.d_data_valid = r_d_dv;
  assign bus.d_rdata      = r_d_rdata;

endmodule
